// File: rtl/PKG_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : PKG_pwm
//  Description : Shared PWM types: on/off control, carrier mode, shadow-load
//                mask mode and the carrier width macro.
//  Revision    : 1.0  initial release
// ============================================================================
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

package PKG_pwm;

    typedef enum logic {
        PWM_OFF = 1'b0,
        PWM_ON  = 1'b1
    } _pwm_onoff;

    typedef enum logic [1:0] {
        CARR_UP     = 2'd0,
        CARR_DOWN   = 2'd1,
        CARR_UPDOWN = 2'd2
    } _carr_mode;

    // bit0 selects the zero event, bit1 selects the period event
    typedef enum logic [1:0] {
        MASK_NONE   = 2'b00,
        MASK_ZERO   = 2'b01,
        MASK_PERIOD = 2'b10,
        MASK_BOTH   = 2'b11
    } _mask_mode;

    // Combine carrier events into the shadow-register load strobe
    function automatic logic mask_hit(input _mask_mode mode,
                                      input logic      zero_hit,
                                      input logic      period_hit);
        return (zero_hit & mode[0]) | (period_hit & mode[1]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_prescaler
//  Description : Clock prescaler. Counts every clk and emits a one-cycle tick
//                when the count equals i_div, then restarts from zero.
//                i_clear holds the count at zero and suppresses the tick.
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_prescaler #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clear,
    input  logic [DIV_WIDTH-1:0] i_div,
    output logic                 o_tick
);

    logic [DIV_WIDTH-1:0] r_count;
    logic                 w_hit;

    assign w_hit  = (r_count == i_div);
    assign o_tick = w_hit & ~i_clear;

    // Free-running divide counter, restarted on tick or clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear || w_hit) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + DIV_WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/pwm_carrier_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_carrier_gen
//  Description : PWM carrier counter (up / down / up-down) with shadowed
//                period, prescaler and single-cycle zero / period / mask
//                update events for the compare shadow registers.
//  Revision    : 1.0  initial release
// ============================================================================
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

module pwm_carrier_gen
    import PKG_pwm::*;
#(
    parameter int CNT_WIDTH = `PWMCOUNT_WIDTH,
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  _pwm_onoff            pwm_onoff,
    input  _carr_mode            carr_mode,
    input  _mask_mode            mask_mode,
    input  logic [CNT_WIDTH-1:0] period,
    input  logic [CNT_WIDTH-1:0] init_val,
    input  logic [DIV_WIDTH-1:0] clk_div,
    output logic [CNT_WIDTH-1:0] carrier,
    output logic                 dir,
    output logic                 zero_evt,
    output logic                 period_evt,
    output logic                 maskevent
);

    logic [CNT_WIDTH-1:0] r_carrier;
    logic [CNT_WIDTH-1:0] r_ps;
    logic                 r_dir;
    logic                 r_zero_evt;
    logic                 r_period_evt;
    logic                 r_maskevent;

    logic                 w_on;
    logic                 w_tick;
    logic [CNT_WIDTH:0]   w_inc;
    logic [CNT_WIDTH-1:0] w_off_val;
    logic [CNT_WIDTH-1:0] w_next;
    logic                 w_next_dir;
    logic                 w_zero_new;
    logic                 w_period_new;

    assign w_on = (pwm_onoff == PWM_ON);

    pwm_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .i_clear (~w_on),
        .i_div   (clk_div),
        .o_tick  (w_tick)
    );

    // One extra bit so that incrementing 2^CNT_WIDTH-1 cannot wrap
    assign w_inc     = {1'b0, r_carrier} + (CNT_WIDTH + 1)'(1);
    assign w_off_val = (init_val > period) ? period : init_val;

    // Next carrier value and direction for the coming tick
    always_comb begin
        w_next     = r_carrier;
        w_next_dir = r_dir;
        case (carr_mode)
            CARR_DOWN: begin
                w_next_dir = 1'b0;
                if ((r_carrier == '0) || (r_carrier > r_ps)) begin
                    w_next = r_ps;
                end else begin
                    w_next = r_carrier - CNT_WIDTH'(1);
                end
            end
            CARR_UPDOWN: begin
                if (r_ps == '0) begin
                    // Degenerate period: pinned at zero, always "rising"
                    w_next     = '0;
                    w_next_dir = 1'b1;
                end else if (r_dir) begin
                    if (w_inc >= {1'b0, r_ps}) begin
                        w_next     = r_ps;
                        w_next_dir = 1'b0;
                    end else begin
                        w_next = w_inc[CNT_WIDTH-1:0];
                    end
                end else begin
                    if (r_carrier > r_ps) begin
                        w_next = r_ps;
                    end else if (r_carrier == '0) begin
                        // Only reachable after a mode change; resume rising
                        w_next     = CNT_WIDTH'(1);
                        w_next_dir = 1'b1;
                    end else begin
                        w_next = r_carrier - CNT_WIDTH'(1);
                        if (r_carrier == CNT_WIDTH'(1)) begin
                            w_next_dir = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_next_dir = 1'b1;
                if (r_carrier >= r_ps) begin
                    w_next = '0;
                end else begin
                    w_next = w_inc[CNT_WIDTH-1:0];
                end
            end
        endcase
    end

    assign w_zero_new   = (w_next == '0);
    assign w_period_new = (w_next == r_ps);

    // Carrier, direction, period shadow and registered event pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_carrier    <= '0;
            r_ps         <= '0;
            r_dir        <= 1'b1;
            r_zero_evt   <= 1'b0;
            r_period_evt <= 1'b0;
            r_maskevent  <= 1'b0;
        end else if (!w_on) begin
            r_ps         <= period;
            r_carrier    <= w_off_val;
            r_dir        <= (carr_mode != CARR_DOWN);
            r_zero_evt   <= 1'b0;
            r_period_evt <= 1'b0;
            r_maskevent  <= 1'b0;
        end else if (w_tick) begin
            r_carrier    <= w_next;
            r_dir        <= w_next_dir;
            r_zero_evt   <= w_zero_new;
            r_period_evt <= w_period_new;
            r_maskevent  <= mask_hit(mask_mode, w_zero_new, w_period_new);
            // New period takes effect from the count after the zero crossing
            if (w_zero_new) begin
                r_ps <= period;
            end
        end else begin
            r_zero_evt   <= 1'b0;
            r_period_evt <= 1'b0;
            r_maskevent  <= 1'b0;
        end
    end

    assign carrier    = r_carrier;
    assign dir        = r_dir;
    assign zero_evt   = r_zero_evt;
    assign period_evt = r_period_evt;
    assign maskevent  = r_maskevent;

endmodule

`default_nettype wire

// File: tb/tb_pwm_carrier_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_carrier_gen
//  Description : Self-checking bench for pwm_carrier_gen. Each scenario pushes
//                the expected {carrier, dir, zero, period, mask} per clock to
//                a queue and pops it when the cycle's outputs are visible.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pwm_carrier_gen;
    import PKG_pwm::*;

    logic        clk = 1'b0;
    logic        reset;
    _pwm_onoff   pwm_onoff;
    _carr_mode   carr_mode;
    _mask_mode   mask_mode;
    logic [15:0] period;
    logic [15:0] init_val;
    logic [7:0]  clk_div;
    logic [15:0] carrier;
    logic        dir;
    logic        zero_evt;
    logic        period_evt;
    logic        maskevent;

    logic [19:0] act;
    logic [19:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    pwm_carrier_gen #(
        .CNT_WIDTH (16),
        .DIV_WIDTH (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pwm_onoff  (pwm_onoff),
        .carr_mode  (carr_mode),
        .mask_mode  (mask_mode),
        .period     (period),
        .init_val   (init_val),
        .clk_div    (clk_div),
        .carrier    (carrier),
        .dir        (dir),
        .zero_evt   (zero_evt),
        .period_evt (period_evt),
        .maskevent  (maskevent)
    );

    always #5 clk = ~clk;

    assign act = {carrier, dir, zero_evt, period_evt, maskevent};

    function automatic logic [19:0] ev(input int c, input logic d, input logic z,
                                       input logic p, input logic m);
        ev = {c[15:0], d, z, p, m};
    endfunction

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input _pwm_onoff on, input _carr_mode cm, input _mask_mode mm,
                             input int p, input int iv, input int dv);
        pwm_onoff = on;
        carr_mode = cm;
        mask_mode = mm;
        period    = p[15:0];
        init_val  = iv[15:0];
        clk_div   = dv[7:0];
    endtask

    task automatic test_reset();
        logic [19:0] want;
        reset = 1'b1;
        configure(PWM_OFF, CARR_UP, MASK_ZERO, 4, 0, 0);
        step();
        step();
        exp_q.push_back(ev(0, 1, 0, 0, 0));
        exp_q.push_back(ev(0, 1, 0, 0, 0));
        for (int i = 0; i < 2; i++) begin
            step();
            want = exp_q.pop_front();
            n_cmp++;
            if (act !== want) begin
                n_err++;
                $display("FAIL reset[%0d]: actual carrier=%0d d/z/p/m=%b required carrier=%0d d/z/p/m=%b",
                         i, act[19:4], act[3:0], want[19:4], want[3:0]);
            end
            if (i == 0) reset = 1'b0;
        end
    endtask

    task automatic test_up();
        logic [19:0] want;
        pwm_onoff = PWM_ON;
        exp_q.push_back(ev(1, 1, 0, 0, 0));
        exp_q.push_back(ev(2, 1, 0, 0, 0));
        exp_q.push_back(ev(3, 1, 0, 0, 0));
        exp_q.push_back(ev(4, 1, 0, 1, 0));
        exp_q.push_back(ev(0, 1, 1, 0, 1));
        exp_q.push_back(ev(1, 1, 0, 0, 0));
        exp_q.push_back(ev(2, 1, 0, 0, 0));
        for (int i = 0; i < 7; i++) begin
            step();
            want = exp_q.pop_front();
            n_cmp++;
            if (act !== want) begin
                n_err++;
                $display("FAIL up[%0d]: actual carrier=%0d d/z/p/m=%b required carrier=%0d d/z/p/m=%b",
                         i, act[19:4], act[3:0], want[19:4], want[3:0]);
            end
        end
    endtask

    task automatic test_updown();
        logic [19:0] want;
        configure(PWM_OFF, CARR_UPDOWN, MASK_BOTH, 3, 0, 0);
        exp_q.push_back(ev(0, 1, 0, 0, 0));
        exp_q.push_back(ev(1, 1, 0, 0, 0));
        exp_q.push_back(ev(2, 1, 0, 0, 0));
        exp_q.push_back(ev(3, 0, 0, 1, 1));
        exp_q.push_back(ev(2, 0, 0, 0, 0));
        exp_q.push_back(ev(1, 0, 0, 0, 0));
        exp_q.push_back(ev(0, 1, 1, 0, 1));
        exp_q.push_back(ev(1, 1, 0, 0, 0));
        for (int i = 0; i < 8; i++) begin
            step();
            want = exp_q.pop_front();
            n_cmp++;
            if (act !== want) begin
                n_err++;
                $display("FAIL updown[%0d]: actual carrier=%0d d/z/p/m=%b required carrier=%0d d/z/p/m=%b",
                         i, act[19:4], act[3:0], want[19:4], want[3:0]);
            end
            if (i == 0) pwm_onoff = PWM_ON;
        end
    endtask

    task automatic test_prescale();
        logic [19:0] want;
        int          vals[17] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 1, 2, 3, 4, 5, 0};
        int          n;
        int          c;
        logic        fresh;
        configure(PWM_OFF, CARR_UP, MASK_NONE, 10, 0, 2);
        exp_q.push_back(ev(0, 1, 0, 0, 0));
        step();
        want = exp_q.pop_front();
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL prescale_off: actual carrier=%0d d/z/p/m=%b required carrier=%0d d/z/p/m=%b",
                     act[19:4], act[3:0], want[19:4], want[3:0]);
        end
        pwm_onoff = PWM_ON;
        for (int k = 0; k <= 50; k++) begin
            if (k < 2) begin
                exp_q.push_back(ev(0, 1, 0, 0, 0));
            end else begin
                n     = (k - 2) / 3;
                c     = vals[n];
                fresh = ((k - 2) % 3 == 0);
                exp_q.push_back(ev(c, 1, fresh && (c == 0),
                                   fresh && (c == ((n <= 10) ? 10 : 5)), 0));
            end
            step();
            want = exp_q.pop_front();
            n_cmp++;
            if (act !== want) begin
                n_err++;
                $display("FAIL prescale[%0d]: actual carrier=%0d d/z/p/m=%b required carrier=%0d d/z/p/m=%b",
                         k, act[19:4], act[3:0], want[19:4], want[3:0]);
            end
            // Mid-cycle period write while the carrier shows 7
            if (k == 21) period = 16'd5;
        end
    endtask

    task automatic test_down();
        logic [19:0] want;
        configure(PWM_OFF, CARR_DOWN, MASK_PERIOD, 4, 9, 0);
        exp_q.push_back(ev(4, 0, 0, 0, 0));
        exp_q.push_back(ev(3, 0, 0, 0, 0));
        exp_q.push_back(ev(2, 0, 0, 0, 0));
        exp_q.push_back(ev(1, 0, 0, 0, 0));
        exp_q.push_back(ev(0, 0, 1, 0, 0));
        exp_q.push_back(ev(4, 0, 0, 1, 1));
        exp_q.push_back(ev(3, 0, 0, 0, 0));
        for (int i = 0; i < 7; i++) begin
            step();
            want = exp_q.pop_front();
            n_cmp++;
            if (act !== want) begin
                n_err++;
                $display("FAIL down[%0d]: actual carrier=%0d d/z/p/m=%b required carrier=%0d d/z/p/m=%b",
                         i, act[19:4], act[3:0], want[19:4], want[3:0]);
            end
            if (i == 0) pwm_onoff = PWM_ON;
        end
    endtask

    task automatic test_zero_period();
        logic [19:0] want;
        _carr_mode   modes[3] = '{CARR_UP, CARR_DOWN, CARR_UPDOWN};
        logic        d;
        for (int m = 0; m < 3; m++) begin
            configure(PWM_OFF, modes[m], MASK_BOTH, 0, 5, 0);
            d = (modes[m] != CARR_DOWN);
            exp_q.push_back(ev(0, d, 0, 0, 0));
            for (int t = 0; t < 3; t++) exp_q.push_back(ev(0, d, 1, 1, 1));
            for (int i = 0; i < 4; i++) begin
                step();
                want = exp_q.pop_front();
                n_cmp++;
                if (act !== want) begin
                    n_err++;
                    $display("FAIL zero_period[m%0d,%0d]: actual carrier=%0d d/z/p/m=%b required carrier=%0d d/z/p/m=%b",
                             m, i, act[19:4], act[3:0], want[19:4], want[3:0]);
                end
                if (i == 0) pwm_onoff = PWM_ON;
            end
        end
    endtask

    task automatic test_max_period();
        logic [19:0] want;
        configure(PWM_OFF, CARR_UP, MASK_BOTH, 65535, 65534, 0);
        exp_q.push_back(ev(65534, 1, 0, 0, 0));
        exp_q.push_back(ev(65535, 1, 0, 1, 1));
        exp_q.push_back(ev(0,     1, 1, 0, 1));
        exp_q.push_back(ev(1,     1, 0, 0, 0));
        exp_q.push_back(ev(65534, 1, 0, 0, 0));
        exp_q.push_back(ev(65535, 0, 0, 1, 1));
        exp_q.push_back(ev(65534, 0, 0, 0, 0));
        exp_q.push_back(ev(65533, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++) begin
            step();
            want = exp_q.pop_front();
            n_cmp++;
            if (act !== want) begin
                n_err++;
                $display("FAIL max_period[%0d]: actual carrier=%0d d/z/p/m=%b required carrier=%0d d/z/p/m=%b",
                         i, act[19:4], act[3:0], want[19:4], want[3:0]);
            end
            if (i == 0) pwm_onoff = PWM_ON;
            if (i == 3) configure(PWM_OFF, CARR_UPDOWN, MASK_BOTH, 65535, 65534, 0);
            if (i == 4) pwm_onoff = PWM_ON;
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0] want;
        configure(PWM_OFF, CARR_UP, MASK_BOTH, 10, 0, 0);
        exp_q.push_back(ev(0, 1, 0, 0, 0));
        for (int v = 1; v <= 6; v++) exp_q.push_back(ev(v, 1, 0, 0, 0));
        exp_q.push_back(ev(0, 1, 0, 0, 0));
        // Shadow period is 0 after reset, so the first tick is a zero/period hit
        exp_q.push_back(ev(0, 1, 1, 1, 1));
        exp_q.push_back(ev(1, 1, 0, 0, 0));
        exp_q.push_back(ev(2, 1, 0, 0, 0));
        for (int i = 0; i < 11; i++) begin
            step();
            want = exp_q.pop_front();
            n_cmp++;
            if (act !== want) begin
                n_err++;
                $display("FAIL reset_mid[%0d]: actual carrier=%0d d/z/p/m=%b required carrier=%0d d/z/p/m=%b",
                         i, act[19:4], act[3:0], want[19:4], want[3:0]);
            end
            if (i == 0) pwm_onoff = PWM_ON;
            if (i == 6) reset = 1'b1;
            if (i == 7) reset = 1'b0;
        end
    endtask

    task automatic test_off_mid();
        logic [19:0] want;
        for (int v = 3; v <= 6; v++) exp_q.push_back(ev(v, 1, 0, 0, 0));
        exp_q.push_back(ev(2, 1, 0, 0, 0));
        exp_q.push_back(ev(2, 1, 0, 0, 0));
        for (int i = 0; i < 6; i++) begin
            step();
            want = exp_q.pop_front();
            n_cmp++;
            if (act !== want) begin
                n_err++;
                $display("FAIL off_mid[%0d]: actual carrier=%0d d/z/p/m=%b required carrier=%0d d/z/p/m=%b",
                         i, act[19:4], act[3:0], want[19:4], want[3:0]);
            end
            if (i == 3) begin
                pwm_onoff = PWM_OFF;
                init_val  = 16'd2;
            end
        end
    endtask

    initial begin
        test_reset();
        test_up();
        test_updown();
        test_prescale();
        test_down();
        test_zero_period();
        test_max_period();
        test_reset_mid();
        test_off_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual time limit reached, required completion before 100000");
        $fatal(1, "bench did not complete");
    end

endmodule

`default_nettype wire
